fp_sub_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 11 +
 rtl/fp_mag_compare.sv | 20 ++
 rtl/fp_sub_seq.sv | 131 +++++++++++++
 tb/tb_fp_sub_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point widths, constants and the sequencer state encoding.
package fp_pkg;
  localparam int FP_EXPONENT = 8;
  localparam int FP_MANTISSA = 23;
  localparam int FP_W = FP_EXPONENT + FP_MANTISSA + 1;
  localparam int FP_BIAS = (1 << (FP_EXPONENT - 1)) - 1;
  localparam logic [FP_W-1:0] POS_ZERO = '0;
  localparam logic [FP_W-1:0] QNAN = {1'b0, {FP_EXPONENT{1'b1}}, 1'b1, {(FP_MANTISSA - 1){1'b0}}};
  localparam logic [FP_EXPONENT-1:0] EXP_MAX = {FP_EXPONENT{1'b1}};
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_e;
endpackage

// File: rtl/fp_mag_compare.sv
// fp_mag_compare: orders two IEEE words by magnitude (ties keep a as big) and returns the exponent gap.
module fp_mag_compare
  import fp_pkg::*;
#(
  parameter int EXPONENT = FP_EXPONENT,
  parameter int MANTISSA = FP_MANTISSA,
  localparam int W = EXPONENT + MANTISSA + 1
) (
  input  logic [W-1:0]        a_i,
  input  logic [W-1:0]        b_i,
  output logic [W-1:0]        big_o,
  output logic [W-1:0]        little_o,
  output logic [EXPONENT-1:0] dif_o
);
  logic swap;
  assign swap = b_i[W-2:0] > a_i[W-2:0];
  assign big_o = swap ? b_i : a_i;
  assign little_o = swap ? a_i : b_i;
  assign dif_o = big_o[W-2 -: EXPONENT] - little_o[W-2 -: EXPONENT];
endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: handshaked sequential a-b with one-bit-per-cycle normalisation and truncation.
// Define FP_SUB_SPECIAL_EN to decode inf/NaN operands at capture and bypass straight to DONE.
module fp_sub_seq
  import fp_pkg::*;
#(
  parameter int EXPONENT = FP_EXPONENT,
  parameter int MANTISSA = FP_MANTISSA,
  localparam int W = EXPONENT + MANTISSA + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         busy
);
  localparam logic [EXPONENT:0] EMAX = {1'b0, {EXPONENT{1'b1}}};
  function automatic logic [W-1:0] flush(input logic [W-1:0] x);
    return (x[W-2 -: EXPONENT] == '0) ? {x[W-1], {(W - 1){1'b0}}} : x;
  endfunction
  function automatic logic [MANTISSA+1:0] mant(input logic [W-1:0] x);
    return {1'b0, |x[W-2 -: EXPONENT], x[MANTISSA-1:0]};
  endfunction
  state_e state_q, state_d;
  logic [W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, big, little;
  logic [EXPONENT-1:0] dif;
  logic [EXPONENT:0] exp_q, exp_d, exp_nx;
  logic [MANTISSA+1:0] big_q, big_d, lit_q, lit_d, sum_q, sum_d, sum_nx;
  logic sign_q, sign_d, vld_q, vld_d;
  fp_mag_compare #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA)) u_cmp (
    .a_i(opa_q), .b_i(opb_q), .big_o(big), .little_o(little), .dif_o(dif)
  );
  // A carry-out is folded in before the DONE decision so overflow sees the final exponent.
  assign exp_nx = sum_q[MANTISSA+1] ? exp_q + 1'b1 : exp_q;
  assign sum_nx = sum_q[MANTISSA+1] ? sum_q >> 1 : sum_q;
`ifdef FP_SUB_SPECIAL_EN
  logic a_max, b_max, sp_nan;
  assign a_max = &a[W-2 -: EXPONENT];
  assign b_max = &b[W-2 -: EXPONENT];
  assign sp_nan = (a_max && |a[MANTISSA-1:0]) || (b_max && |b[MANTISSA-1:0]) ||
                  (a_max && b_max && a[W-1] == b[W-1]);
`endif
  always_comb begin
    state_d = state_q;
    opa_d = opa_q;
    opb_d = opb_q;
    sign_d = sign_q;
    exp_d = exp_q;
    big_d = big_q;
    lit_d = lit_q;
    sum_d = sum_q;
    vld_d = vld_q;
    res_d = res_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        opa_d = flush(a);
        opb_d = flush({~b[W-1], b[W-2:0]});
        state_d = S_ALIGN;
`ifdef FP_SUB_SPECIAL_EN
        if (a_max || b_max) begin
          sign_d = sp_nan ? 1'b0 : (a_max ? a[W-1] : ~b[W-1]);
          exp_d = EMAX;
          sum_d = sp_nan ? {2'b0, 1'b1, {(MANTISSA - 1){1'b0}}} : '0;
          state_d = S_DONE;
        end
`endif
      end
      S_ALIGN: begin
        sign_d = big[W-1];
        exp_d = {1'b0, big[W-2 -: EXPONENT]};
        big_d = mant(big);
        lit_d = (int'(dif) > MANTISSA + 1) ? '0 : mant(little) >> dif;
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d = (big[W-1] == little[W-1]) ? big_q + lit_q : big_q - lit_q;
        state_d = S_NORM;
      end
      S_NORM: if (sum_q == '0) begin
        sign_d = 1'b0;
        exp_d = '0;
        state_d = S_DONE;
      end else if (sum_q[MANTISSA+1] || sum_q[MANTISSA]) begin
        exp_d = (exp_nx >= EMAX) ? EMAX : exp_nx;
        sum_d = (exp_nx >= EMAX) ? '0 : sum_nx;
        state_d = S_DONE;
      end else if (exp_q[EXPONENT:1] == '0) begin
        exp_d = '0;
        sum_d = '0;
        state_d = S_DONE;
      end else begin
        exp_d = exp_q - 1'b1;
        sum_d = sum_q << 1;
      end
      S_DONE: if (!vld_q) begin
        vld_d = 1'b1;
        res_d = {sign_q, exp_q[EXPONENT-1:0], sum_q[MANTISSA-1:0]};
      end else if (out_ready) begin
        vld_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld_q <= 1'b0;
      res_q <= POS_ZERO;
    end else begin
      state_q <= state_d;
      vld_q <= vld_d;
      res_q <= res_d;
    end
    opa_q <= opa_d;
    opb_q <= opb_d;
    sign_q <= sign_d;
    exp_q <= exp_d;
    big_q <= big_d;
    lit_q <= lit_d;
    sum_q <= sum_d;
  end
  assign in_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign out_valid = vld_q;
  assign result = res_q;
endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: random and directed a-b transactions scored against a value-level subtract model.
module tb_fp_sub_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] a = 0, b = 0, result;
  logic in_ready, out_valid, busy;
  fp_sub_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0, checks = 0, acc_cyc = 0, exp_lat = 0;
  logic pend = 0, armed = 0;
  logic [31:0] exp_r = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void model(input logic [31:0] ta, input logic [31:0] tb_, output logic [31:0] r, output int lat);
    logic [31:0] x, y, bg, lt;
    longint mb, ml, s;
    int e, d, sh;
    x = ta;
    y = {~tb_[31], tb_[30:0]};
    lat = 4;
`ifdef FP_SUB_SPECIAL_EN
    if (ta[30:23] == 8'hff || tb_[30:23] == 8'hff) begin
      lat = 1;
      if ((ta[30:23] == 8'hff && ta[22:0] != 0) || (tb_[30:23] == 8'hff && tb_[22:0] != 0) ||
          (ta[30:23] == 8'hff && tb_[30:23] == 8'hff && ta[31] == tb_[31])) r = 32'h7fc00000;
      else if (ta[30:23] == 8'hff) r = {ta[31], 8'hff, 23'b0};
      else r = {~tb_[31], 8'hff, 23'b0};
      return;
    end
`endif
    if (x[30:23] == 0) x = {x[31], 31'b0};
    if (y[30:23] == 0) y = {y[31], 31'b0};
    if (x[30:0] >= y[30:0]) begin bg = x; lt = y; end
    else begin bg = y; lt = x; end
    mb = (bg[30:23] != 0) ? longint'({1'b1, bg[22:0]}) : 0;
    ml = (lt[30:23] != 0) ? longint'({1'b1, lt[22:0]}) : 0;
    d = int'(bg[30:23]) - int'(lt[30:23]);
    ml = (d > 24) ? 0 : (ml >> d);
    s = (bg[31] == lt[31]) ? mb + ml : mb - ml;
    e = int'(bg[30:23]);
    sh = 0;
    if (s == 0) begin
      r = 0;
    end else begin
      if (s >= (64'd1 << 24)) begin s = s >> 1; e++; end
      while (s < (64'd1 << 23) && e > 1) begin s = s << 1; e--; sh++; end
      if (s < (64'd1 << 23)) r = {bg[31], 31'b0};
      else if (e >= 255) r = {bg[31], 8'hff, 23'b0};
      else r = {bg[31], e[7:0], s[22:0]};
    end
    lat = 4 + sh;
  endfunction

  // Per-cycle scoreboard: handshake flags always, result whenever it is presented.
  always @(negedge clk) if (armed) begin
    chk("in_ready", {31'b0, in_ready}, {31'b0, !pend});
    chk("busy", {31'b0, busy}, {31'b0, pend});
    chk("out_valid", {31'b0, out_valid}, {31'b0, pend && cyc >= acc_cyc + exp_lat});
    if (out_valid) chk("result", result, exp_r);
  end

  task automatic run(input logic [31:0] ta, input logic [31:0] tb_, input int hold,
                     input logic pin, input logic [31:0] lit_r, input int lit_lat);
    logic [31:0] mr;
    int ml, n;
    model(ta, tb_, mr, ml);
    if (pin) begin
      chk("model_res", mr, lit_r);
      chk("model_lat", 32'(ml), 32'(lit_lat));
    end
    a = ta;
    b = tb_;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    exp_r = mr;
    exp_lat = ml;
    acc_cyc = cyc;
    pend = 1;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(cyc - acc_cyc), 32'(ml));
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    pend = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    int mr_lat;
    logic [31:0] mr;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    armed = 1;
    run(32'h40400000, 32'h3f800000, 0, 1, 32'h40000000, 4);
    run(32'h3f800000, 32'hbf800000, 0, 1, 32'h40000000, 4);
    run(32'h3f800000, 32'h3f800000, 0, 1, 32'h00000000, 4);
    run(32'h3f800000, 32'h3f7fffff, 0, 1, 32'h34000000, 27);
    run(32'h40400000, 32'h3f800000, 10, 1, 32'h40000000, 4);
    run(32'h00400000, 32'h3f800000, 1, 1, 32'hbf800000, 4);
    run(32'h7f7fffff, 32'hff7fffff, 0, 1, 32'h7f800000, 4);
    run(32'h00800000, 32'h00800001, 0, 1, 32'h80000000, 4);
`ifdef FP_SUB_SPECIAL_EN
    run(32'h7f800000, 32'h7f800000, 0, 1, 32'h7fc00000, 1);
    run(32'h3f800000, 32'hff800000, 0, 1, 32'h7f800000, 1);
`endif
    // Abort a long normalisation midway; the block must come back clean.
    model(32'h3f800000, 32'h3f7fffff, mr, mr_lat);
    a = 32'h3f800000;
    b = 32'h3f7fffff;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    exp_r = mr;
    exp_lat = mr_lat;
    acc_cyc = cyc;
    pend = 1;
    repeat (8) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    pend = 0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    run(32'h40400000, 32'h3f800000, 0, 1, 32'h40000000, 4);
    for (int i = 0; i < 80; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 2))
        0: rb = $urandom;
        1: rb = {1'($urandom), ra[30:23] - 8'($urandom_range(0, 3)), 23'($urandom)};
        default: rb = ra ^ 32'($urandom_range(0, 255));
      endcase
      run(ra, rb, $urandom_range(0, 3), 0, 0, 0);
    end
    armed = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
